// File: rtl/radix4_seq_mult.sv
// Sequential unsigned W x W radix-4 Booth multiplier with valid/ready handshakes.
// Optional truncation of the low TRUNC product columns when RADIX4_TRUNC_EN is defined.
module radix4_seq_mult #(
  parameter int unsigned W     = 8,
  parameter int unsigned TRUNC = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned AW = 2*W + 2;
  localparam int unsigned YW = W + 3;
  localparam int unsigned N  = W/2 + 1;
  localparam int unsigned CW = $clog2(N + 1);

`ifdef RADIX4_TRUNC_EN
  localparam bit TRUNC_ON = 1'b1;
`else
  localparam bit TRUNC_ON = 1'b0;
`endif

  localparam logic [AW-1:0] KEEP_MASK =
    TRUNC_ON ? ~((AW'(1) << TRUNC) - AW'(1)) : {AW{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [AW-1:0] xsh;
  logic [YW-1:0] ysh;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] pp_c;
  logic [AW-1:0] sum_c;

  // Booth digit select on the current triplet; xsh already carries the 4^i weight
  always_comb begin
    pp_c = '0;
    case (ysh[2:0])
      3'b001, 3'b010: pp_c = xsh;
      3'b011:         pp_c = xsh << 1;
      3'b100:         pp_c = -(xsh << 1);
      3'b101, 3'b110: pp_c = -xsh;
      default:        pp_c = '0;
    endcase
    pp_c  = pp_c & KEEP_MASK;
    sum_c = acc + pp_c;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      acc       <= '0;
      cnt       <= '0;
      xsh       <= '0;
      ysh       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xsh      <= AW'(x);
            ysh      <= {2'b00, y, 1'b0};
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= sum_c;
          xsh <= xsh << 2;
          ysh <= ysh >> 2;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            p         <= sum_c[2*W-1:0];
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_seq_mult.sv
// Randomised self-checking bench for radix4_seq_mult against an arithmetic reference.
// Define RADIX4_TRUNC_EN for both files to check the truncated build.
module tb_radix4_seq_mult;

  localparam int unsigned W     = 8;
  localparam int unsigned TRUNC = 4;
  localparam int unsigned N     = W/2 + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  radix4_seq_mult #(.W(W), .TRUNC(TRUNC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference product from the recoding rules using plain integer arithmetic
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RADIX4_TRUNC_EN
    longint s, yv, term;
    int t, d;
    s  = 0;
    yv = longint'(b) << 1;
    for (int i = 0; i < int'(N); i++) begin
      t = int'((yv >> (2*i)) & 64'd7);
      case (t)
        1, 2:    d = 1;
        3:       d = 2;
        4:       d = -2;
        5, 6:    d = -1;
        default: d = 0;
      endcase
      term = longint'(d) * longint'(a) * (longint'(1) << (2*i));
      term = term & ~((longint'(1) << TRUNC) - 1);
      s = s + term;
    end
    return (2*W)'(s);
`else
    return (2*W)'(a) * (2*W)'(b);
`endif
  endfunction

  // One full transaction starting at a negedge; hold = DONE cycles with out_ready low
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [2*W-1:0] e;
    int n;
    e = ref_prod(a, b);
    x = a; y = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom);
    chk("in_ready_low", 64'(in_ready), 64'd0);
    chk("busy_high", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 64'(n), 64'(N));
    chk("product", 64'(p), 64'(e));
`ifdef RADIX4_TRUNC_EN
    chk("trunc_cols", 64'(p) & ((64'd1 << TRUNC) - 64'd1), 64'd0);
`endif
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_p", 64'(p), 64'(e));
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_valid", 64'(out_valid), 64'd0);
    chk("back_ready", 64'(in_ready), 64'd1);
    chk("p_kept", 64'(p), 64'(e));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, n, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(8'd254, 8'd254, 0);
    txn(8'd255, 8'd255, 0);
    txn(8'd0, 8'd200, 0);
    txn(8'd170, 8'd85, 10);
`ifdef RADIX4_TRUNC_EN
    txn(8'd1, 8'd1, 0);
    chk("trunc_1x1", 64'(p), 64'd0);
    txn(8'd16, 8'd16, 0);
    chk("trunc_16x16", 64'(p), 64'd256);
`endif

    // Reset while the digit counter is at 2
    x = 8'd100; y = 8'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_p", 64'(p), 64'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("midrst_no_output", 64'(seen), 64'd0);
    txn(8'd3, 8'd7, 0);

    for (int t = 0; t < 500; t++) begin
      hold = 0;
      n = 0;
      while (($urandom % 2) != 0 && n < 4) begin hold++; n++; end
      txn(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
